// File: rtl/imm_pkg.sv
// Shared encodings for the immediate generator: format selects, RV opcodes,
// funct3 values that pick shift/CSR-immediate variants, and the opcode decoder.
package imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_Z   = 3'b101,
    IMM_SH  = 3'b110,
    IMM_RSV = 3'b111
  } imm_sel_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_SLL    = 3'b001;
  localparam logic [2:0] F3_SRX    = 3'b101;
  localparam logic [2:0] F3_CSRRWI = 3'b101;
  localparam logic [2:0] F3_CSRRSI = 3'b110;
  localparam logic [2:0] F3_CSRRCI = 3'b111;

  // Unknown opcodes map to IMM_RSV so the extractor flags them illegal.
  function automatic imm_sel_e decode_fmt(input logic [6:0] op, input logic [2:0] f3,
                                          input logic rv64);
    logic     is_sh;
    imm_sel_e fmt;
    is_sh = (f3 == F3_SLL) || (f3 == F3_SRX);
    fmt   = IMM_RSV;
    case (op)
      OP_IMM:           fmt = is_sh ? IMM_SH : IMM_I;
      OP_LOAD, OP_JALR: fmt = IMM_I;
      OP_IMM32:         fmt = rv64 ? (is_sh ? IMM_SH : IMM_I) : IMM_RSV;
      OP_STORE:         fmt = IMM_S;
      OP_BRANCH:        fmt = IMM_B;
      OP_LUI, OP_AUIPC: fmt = IMM_U;
      OP_JAL:           fmt = IMM_J;
      OP_SYSTEM:        fmt = ((f3 == F3_CSRRWI) || (f3 == F3_CSRRSI) || (f3 == F3_CSRRCI))
                              ? IMM_Z : IMM_I;
      default:          fmt = IMM_RSV;
    endcase
    return fmt;
  endfunction

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Handshake bundle between the decode front-end, the immediate generator and its consumer.
interface imm_gen_pipe_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);
  import imm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [31:0]      Instr;
  imm_sel_e         ImmSel;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  ExtImm;
  imm_sel_e         ImmFmt;
  logic             ImmIllegal;
  logic [CNT_W-1:0] IllegalCnt;

  modport master (
    output in_valid, Instr, ImmSel, out_ready,
    input  in_ready, out_valid, ExtImm, ImmFmt, ImmIllegal, IllegalCnt
  );

  modport slave (
    input  in_valid, Instr, ImmSel, out_ready,
    output in_ready, out_valid, ExtImm, ImmFmt, ImmIllegal, IllegalCnt
  );
endinterface

// File: rtl/imm_fmt_extract.sv
// Combinational immediate extraction for one RV format, sized to XLEN.
// Opcode bits [6:0] never contribute to an immediate, so only [31:7] is taken.
module imm_fmt_extract
  import imm_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:7]     instr_i,
  input  imm_sel_e        fmt_i,
  output logic [XLEN-1:0] imm_o,
  output logic            illegal_o
);

  logic signed [11:0] imm_i12;
  logic signed [11:0] imm_s12;
  logic signed [12:0] imm_b13;
  logic signed [31:0] imm_u32;
  logic signed [20:0] imm_j21;

  always_comb begin
    imm_i12   = instr_i[31:20];
    imm_s12   = {instr_i[31:25], instr_i[11:7]};
    imm_b13   = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    imm_u32   = {instr_i[31:12], 12'b0};
    imm_j21   = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    imm_o     = '0;
    illegal_o = 1'b0;
    // Signed size casts sign-extend to XLEN; Z and SH are unsigned and zero-extend.
    case (fmt_i)
      IMM_I:   imm_o = XLEN'(imm_i12);
      IMM_S:   imm_o = XLEN'(imm_s12);
      IMM_B:   imm_o = XLEN'(imm_b13);
      IMM_U:   imm_o = XLEN'(imm_u32);
      IMM_J:   imm_o = XLEN'(imm_j21);
      IMM_Z:   imm_o = XLEN'(instr_i[19:15]);
      IMM_SH:  imm_o = (XLEN == 64) ? XLEN'(instr_i[25:20]) : XLEN'(instr_i[24:20]);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator: output register plus one skid entry, FIFO ordered,
// with a saturating count of illegal results handed to the consumer.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter bit AUTO_DECODE = 1'b0,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           flush,
  imm_gen_pipe_if.slave  bus
);

  typedef struct packed {
    logic [XLEN-1:0] imm;
    imm_sel_e        fmt;
    logic            illegal;
  } entry_t;

  imm_sel_e        fmt_sel;
  logic [XLEN-1:0] in_imm;
  logic            in_ill;
  entry_t          in_ent;

  entry_t          out_q, out_d, skid_q, skid_d;
  logic            out_vld_q, out_vld_d, skid_vld_q, skid_vld_d;
  logic            rdy_q, rdy_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            push, pop;

  assign fmt_sel = AUTO_DECODE ? decode_fmt(bus.Instr[6:0], bus.Instr[14:12], XLEN == 64)
                               : bus.ImmSel;

  imm_fmt_extract #(.XLEN(XLEN)) u_extract (
    .instr_i   (bus.Instr[31:7]),
    .fmt_i     (fmt_sel),
    .imm_o     (in_imm),
    .illegal_o (in_ill)
  );

  assign in_ent = '{imm: in_imm, fmt: fmt_sel, illegal: in_ill};
  assign push   = bus.in_valid && rdy_q;
  assign pop    = out_vld_q && bus.out_ready;

  always_comb begin
    out_d      = out_q;
    out_vld_d  = out_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    cnt_d      = cnt_q;
    if (flush) begin
      out_vld_d  = 1'b0;
      skid_vld_d = 1'b0;
    end else begin
      if (pop && out_q.illegal && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
      // Output slot frees up: refill from skid first to keep FIFO order.
      if (pop || !out_vld_q) begin
        if (skid_vld_q) begin
          out_d      = skid_q;
          out_vld_d  = 1'b1;
          skid_vld_d = push;
          if (push) skid_d = in_ent;
        end else begin
          out_vld_d = push;
          if (push) out_d = in_ent;
        end
      end else if (push) begin
        skid_d     = in_ent;
        skid_vld_d = 1'b1;
      end
    end
    rdy_d = !skid_vld_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      rdy_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      out_q      <= out_d;
      skid_q     <= skid_d;
      out_vld_q  <= out_vld_d;
      skid_vld_q <= skid_vld_d;
      rdy_q      <= rdy_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready   = rdy_q;
  assign bus.out_valid  = out_vld_q;
  assign bus.ExtImm     = out_q.imm;
  assign bus.ImmFmt     = out_q.fmt;
  assign bus.ImmIllegal = out_q.illegal;
  assign bus.IllegalCnt = cnt_q;

endmodule
